// File: rtl/car_motion_pkg.sv
// Shared definitions for the elevator car: state encoding, floor geometry and
// direction constants.
package car_motion_pkg;

  localparam int FLOOR_W    = 3;
  localparam int NUM_FLOORS = 8;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MOVE  = 2'd1,
    ST_DOORS = 2'd2
  } state_t;

endpackage

// File: rtl/car_motion_cycle_timer.sv
// Up-counter with clear, enable and a terminal-count compare. One instance
// serves both floor travel and door dwell; the caller muxes the terminal value.
module cycle_timer #(
  parameter int TW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  input  logic [TW-1:0] term,
  output logic [TW-1:0] count,
  output logic          done
);

  // count advances while enabled; clear wins so every state entry starts at 0
  always_ff @(posedge clk) begin
    if (reset || clear) count <= '0;
    else if (enable)    count <= count + 1'b1;
  end

  assign done = (count == term);

endmodule

// File: rtl/car_motion.sv
// Simulated elevator car: consumes the call controller's move decision and
// pending calls, times travel and door dwell, and reports floor / arrival.
module car_motion
  import car_motion_pkg::*;
#(
  parameter int FLOORS        = NUM_FLOORS,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 32,
  parameter int TW            = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               should_move,
  input  logic               direction,
  input  logic [FLOORS-1:0]  call_inside,
  input  logic [FLOORS-1:0]  call_up,
  input  logic [FLOORS-1:0]  call_down,
  output logic [FLOOR_W-1:0] cur_floor,
  output logic               moving,
  output logic               moving_dir,
  output logic               door_open,
  output logic               floor_reached
);

  localparam logic [TW-1:0]      TRAVEL_TC = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0]      DOOR_TC   = TW'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOORS - 1);

  state_t              state_q, state_d;
  logic [FLOORS-1:0]   call_all;
  logic                call_here;
  logic                tmr_clr, tmr_en, tmr_done, step_en, dir_ld;
  logic [TW-1:0]       tmr_cnt, tmr_term;
  logic [FLOOR_W-1:0]  floor_d;

  assign call_all  = call_inside | call_up | call_down;
  assign call_here = call_all[cur_floor];

  assign tmr_en   = (state_q != ST_IDLE);
  assign tmr_term = (state_q == ST_DOORS) ? DOOR_TC : TRAVEL_TC;

  cycle_timer #(.TW(TW)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clr),
    .enable (tmr_en),
    .term   (tmr_term),
    .count  (tmr_cnt),
    .done   (tmr_done)
  );

  // next-state: a call at this floor beats travel; a fresh call during dwell
  // (timer past 0) restarts the dwell instead of closing the doors
  always_comb begin
    state_d = state_q;
    tmr_clr = 1'b0;
    step_en = 1'b0;
    dir_ld  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmr_clr = 1'b1;
        if (call_here) begin
          state_d = ST_DOORS;
        end else if (should_move) begin
          state_d = ST_MOVE;
          dir_ld  = 1'b1;
        end
      end
      ST_MOVE: begin
        if (tmr_done) begin
          step_en = 1'b1;
          tmr_clr = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DOORS: begin
        if (call_here && (tmr_cnt != '0)) begin
          tmr_clr = 1'b1;
        end else if (tmr_done) begin
          tmr_clr = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        tmr_clr = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // saturating floor step: a move past either end still burns the travel time
  always_comb begin
    floor_d = cur_floor;
    if (step_en) begin
      if (moving_dir == DIR_UP) begin
        if (cur_floor != TOP_FLOOR) floor_d = cur_floor + 1'b1;
      end else begin
        if (cur_floor != '0) floor_d = cur_floor - 1'b1;
      end
    end
  end

  // state, floor and registered status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cur_floor     <= '0;
      moving_dir    <= DIR_UP;
      moving        <= 1'b0;
      door_open     <= 1'b0;
      floor_reached <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_floor     <= floor_d;
      if (dir_ld) moving_dir <= direction;
      moving        <= (state_d == ST_MOVE);
      door_open     <= (state_d == ST_DOORS);
      floor_reached <= (state_d == ST_DOORS);
    end
  end

endmodule

// File: tb/tb_car_motion.sv
// Bench for car_motion with short travel/dwell times: a fixed vector table,
// hand-written corner sequences and random stimulus, all checked against a
// behavioural model of the car.
module tb_car_motion;

  localparam int T = 4;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset, should_move, direction;
  logic [7:0] ci, cu, cd;
  logic [2:0] cur_floor;
  logic       moving, moving_dir, door_open, floor_reached;

  int n_chk  = 0;
  int n_pass = 0;

  // model state: phase 0 = idle, 1 = travelling, 2 = doors open
  int m_floor = 0;
  int m_phase = 0;
  int m_cnt   = 0;
  bit m_dir   = 1'b1;

  always #5 clk = ~clk;

  car_motion #(.FLOORS(8), .TRAVEL_CYCLES(T), .DOOR_CYCLES(D), .TW(6)) dut (
    .clk           (clk),
    .reset         (reset),
    .should_move   (should_move),
    .direction     (direction),
    .call_inside   (ci),
    .call_up       (cu),
    .call_down     (cd),
    .cur_floor     (cur_floor),
    .moving        (moving),
    .moving_dir    (moving_dir),
    .door_open     (door_open),
    .floor_reached (floor_reached)
  );

  function automatic logic [6:0] dut_pack();
    return {cur_floor, moving, moving_dir, door_open, floor_reached};
  endfunction

  function automatic logic [6:0] model_pack();
    return {3'(m_floor), m_phase == 1, m_dir, m_phase == 2, m_phase == 2};
  endfunction

  // one rising edge of the car as described in prose terms
  task automatic model_edge();
    logic [7:0] all;
    bit here;
    all  = ci | cu | cd;
    here = all[m_floor];
    if (reset) begin
      m_floor = 0; m_phase = 0; m_cnt = 0; m_dir = 1'b1;
    end else if (m_phase == 0) begin
      if (here) begin
        m_phase = 2; m_cnt = 0;
      end else if (should_move) begin
        m_phase = 1; m_cnt = 0; m_dir = direction;
      end
    end else if (m_phase == 1) begin
      if (m_cnt == T - 1) begin
        if (m_dir && m_floor < 7) m_floor = m_floor + 1;
        if (!m_dir && m_floor > 0) m_floor = m_floor - 1;
        m_phase = 0; m_cnt = 0;
      end else m_cnt = m_cnt + 1;
    end else begin
      if (here && m_cnt != 0) m_cnt = 0;
      else if (m_cnt == D - 1) begin
        m_phase = 0; m_cnt = 0;
      end else m_cnt = m_cnt + 1;
    end
  endtask

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got {floor,mv,dir,door,fr}=%b required %b at %0t", name, act, exp, $time);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("model", dut_pack(), model_pack());
  endtask

  task automatic drive(input bit r, input bit sm, input bit dir,
                       input logic [7:0] i, input logic [7:0] u, input logic [7:0] d);
    reset = r; should_move = sm; direction = dir; ci = i; cu = u; cd = d;
  endtask

  typedef struct {
    bit         rst;
    bit         sm;
    bit         dir;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int doors, got_door, floor_at_door, mv_cnt;
    drive(1, 0, 0, 8'h00, 8'h00, 8'h00);

    // reset then two floors of upward travel, expected values written out
    tbl[0] = '{1, 0, 0, 7'b000_0_1_0_0};
    for (int i = 1; i <= 4; i++) tbl[i] = '{0, 1, 1, 7'b000_1_1_0_0};
    tbl[5] = '{0, 1, 1, 7'b001_0_1_0_0};
    for (int i = 6; i <= 9; i++) tbl[i] = '{0, 1, 1, 7'b001_1_1_0_0};
    tbl[10] = '{0, 1, 1, 7'b010_0_1_0_0};
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].rst, tbl[i].sm, tbl[i].dir, 8'h00, 8'h00, 8'h00);
      tick();
      check($sformatf("table[%0d]", i), dut_pack(), tbl[i].exp);
    end

    // idle with nothing to do stays put
    drive(1, 0, 0, 8'h00, 8'h00, 8'h00); tick();
    drive(0, 0, 0, 8'h00, 8'h00, 8'h00);
    for (int k = 0; k < 20; k++) begin
      tick();
      check("idle_hold", dut_pack(), 7'b000_0_1_0_0);
    end

    // in-car call at 3 while travelling up; should_move stays high in doors
    drive(1, 0, 0, 8'h00, 8'h00, 8'h00); tick();
    drive(0, 1, 1, 8'h08, 8'h00, 8'h00);
    got_door = 0;
    for (int k = 0; k < 60 && !door_open; k++) tick();
    got_door = door_open;
    check_int("t3_door_reached", got_door, 1);
    floor_at_door = cur_floor;
    check_int("t3_floor_at_door", floor_at_door, 3);
    ci = 8'h00;
    doors = 0;
    for (int k = 0; k < 20; k++) begin
      if (!door_open) break;
      doors++;
      tick();
    end
    check_int("t3_dwell_cycles", doors, D);
    check_int("t3_floor_after", cur_floor, 3);

    // fresh hall call at timer=2 restarts the dwell: 3 + 4 cycles open
    drive(1, 0, 0, 8'h00, 8'h00, 8'h00); tick();
    drive(0, 1, 1, 8'h08, 8'h00, 8'h00);
    for (int k = 0; k < 60 && !door_open; k++) tick();
    check_int("t4_door_reached", door_open, 1);
    drive(0, 0, 1, 8'h00, 8'h00, 8'h00);
    doors = 0;
    for (int k = 0; k < 30; k++) begin
      if (!door_open) break;
      doors++;
      if (k == 2) cu = 8'h08;
      tick();
      cu = 8'h00;
    end
    check_int("t4_dwell_cycles", doors, 7);

    // top floor: moving up burns travel time without wrapping
    drive(1, 0, 0, 8'h00, 8'h00, 8'h00); tick();
    drive(0, 1, 1, 8'h00, 8'h00, 8'h00);
    for (int k = 0; k < 7 * (T + 1); k++) tick();
    check("t5_at_top", dut_pack(), 7'b111_0_1_0_0);
    mv_cnt = 0;
    for (int k = 0; k < T + 1; k++) begin
      tick();
      if (moving) mv_cnt++;
    end
    check_int("t5_top_move_cycles", mv_cnt, T);
    check_int("t5_top_floor", cur_floor, 7);

    // bottom floor mirror
    drive(1, 0, 0, 8'h00, 8'h00, 8'h00); tick();
    drive(0, 1, 0, 8'h00, 8'h00, 8'h00);
    mv_cnt = 0;
    for (int k = 0; k < T + 1; k++) begin
      tick();
      if (moving) mv_cnt++;
    end
    check_int("t5_bot_move_cycles", mv_cnt, T);
    check("t5_at_bottom", dut_pack(), 7'b000_0_0_0_0);

    // reset in the middle of travel out of floor 1
    drive(1, 0, 0, 8'h00, 8'h00, 8'h00); tick();
    drive(0, 1, 1, 8'h00, 8'h00, 8'h00);
    for (int k = 0; k < T + 1 + 3; k++) tick();
    check("t6_mid_move", dut_pack(), 7'b001_1_1_0_0);
    drive(1, 1, 1, 8'h00, 8'h00, 8'h00); tick();
    check("t6_reset_move", dut_pack(), 7'b000_0_1_0_0);

    // reset in the middle of a dwell
    drive(0, 0, 1, 8'h01, 8'h00, 8'h00); tick();
    ci = 8'h00; tick();
    check("t6_mid_doors", dut_pack(), 7'b000_0_1_1_1);
    drive(1, 0, 1, 8'h00, 8'h00, 8'h00); tick();
    check("t6_reset_doors", dut_pack(), 7'b000_0_1_0_0);

    // random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      reset       = ($urandom_range(0, 199) == 0);
      should_move = 1'($urandom_range(0, 1));
      direction   = 1'($urandom_range(0, 1));
      ci = ($urandom_range(0, 7) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      cu = ($urandom_range(0, 9) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      cd = ($urandom_range(0, 9) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
